// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory port arbiter.
package dmem_arb_pkg;

    typedef enum logic {
        ARB_CPU      = 1'b0,
        ARB_AUX_RESP = 1'b1
    } state_t;

    localparam logic [3:0]  DMEM_XFER_DWORD = 4'd8;
    localparam int unsigned WAIT_CNT_W      = 8;

endpackage

// File: rtl/dmem_arb_starve_ctr.sv
// AUX starvation counter: counts blocked AUX cycles and raises force_gnt
// once the wait reaches MAX_WAIT.
module dmem_arb_starve_ctr
    import dmem_arb_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic aux_req,
    input  logic cpu_active,
    input  logic aux_gnt,
    output logic force_gnt
);

    localparam logic [WAIT_CNT_W-1:0] WAIT_LIMIT = WAIT_CNT_W'(MAX_WAIT);

    logic [WAIT_CNT_W-1:0] wait_cnt;

    assign force_gnt = aux_req & cpu_active & (wait_cnt == WAIT_LIMIT);

    // A forced cycle is always a grant, so the counter never passes WAIT_LIMIT.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt <= '0;
        end else if (!aux_req || aux_gnt) begin
            wait_cnt <= '0;
        end else if (cpu_active && !force_gnt) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Arbitrates the single datamem port between the MEM-stage CPU access and an AUX requester.
// Optional statistics counters are enabled by defining DMEM_ARB_STATS_EN.
module dmem_port_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_rd_en,
    input  logic        cpu_wr_en,
    input  logic [63:0] cpu_addr,
    input  logic [63:0] cpu_wdata,
    output logic [63:0] cpu_rdata,
    output logic        cpu_stall,
    input  logic        aux_req,
    input  logic        aux_we,
    input  logic [63:0] aux_addr,
    input  logic [63:0] aux_wdata,
    output logic        aux_gnt,
    output logic [63:0] aux_rdata,
    output logic        aux_rvalid,
    output logic [63:0] mem_address,
    output logic        mem_write_enable,
    output logic        mem_read_enable,
    output logic [63:0] mem_write_data,
    output logic [3:0]  mem_xfer_size,
    input  logic [63:0] mem_read_data
`ifdef DMEM_ARB_STATS_EN
    ,
    output logic [31:0] stat_stall_cycles,
    output logic [31:0] stat_aux_grants
`endif
);

    logic   cpu_active;
    logic   force_gnt;
    state_t state, state_nxt;

    assign cpu_active    = cpu_rd_en | cpu_wr_en;
    assign cpu_rdata     = mem_read_data;
    assign mem_xfer_size = DMEM_XFER_DWORD;

    dmem_arb_starve_ctr #(
        .MAX_WAIT (MAX_WAIT)
    ) u_starve_ctr (
        .clk        (clk),
        .reset      (reset),
        .aux_req    (aux_req),
        .cpu_active (cpu_active),
        .aux_gnt    (aux_gnt),
        .force_gnt  (force_gnt)
    );

    always_comb begin
        aux_gnt          = aux_req & (~cpu_active | force_gnt);
        cpu_stall        = aux_gnt & force_gnt;
        mem_address      = '0;
        mem_write_data   = '0;
        mem_write_enable = 1'b0;
        mem_read_enable  = 1'b0;
        if (aux_gnt) begin
            mem_address      = aux_addr;
            mem_write_data   = aux_wdata;
            mem_write_enable = aux_we;
            mem_read_enable  = ~aux_we;
        end else if (cpu_active) begin
            mem_address      = cpu_addr;
            mem_write_data   = cpu_wdata;
            mem_write_enable = cpu_wr_en;
            mem_read_enable  = cpu_rd_en;
        end
    end

    // The response state never blocks arbitration; a back-to-back AUX read re-enters it.
    always_comb begin
        state_nxt  = (aux_gnt && !aux_we) ? ARB_AUX_RESP : ARB_CPU;
        aux_rvalid = (state == ARB_AUX_RESP);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ARB_CPU;
            aux_rdata <= '0;
        end else begin
            state <= state_nxt;
            if (aux_gnt && !aux_we) begin
                aux_rdata <= mem_read_data;
            end
        end
    end

`ifdef DMEM_ARB_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_stall_cycles <= '0;
            stat_aux_grants   <= '0;
        end else begin
            if (cpu_stall && stat_stall_cycles != '1) begin
                stat_stall_cycles <= stat_stall_cycles + 1'b1;
            end
            if (aux_gnt && stat_aux_grants != '1) begin
                stat_aux_grants <= stat_aux_grants + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Self-checking bench for dmem_port_arbiter with a behavioural datamem and an AUX read scoreboard.
module tb_dmem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_rd_en, cpu_wr_en;
    logic [63:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        cpu_stall;
    logic        aux_req, aux_we;
    logic [63:0] aux_addr, aux_wdata, aux_rdata;
    logic        aux_gnt, aux_rvalid;
    logic [63:0] mem_address, mem_write_data, mem_read_data;
    logic        mem_write_enable, mem_read_enable;
    logic [3:0]  mem_xfer_size;
`ifdef DMEM_ARB_STATS_EN
    logic [31:0] stat_stall_cycles, stat_aux_grants;
`endif

    int unsigned total = 0;
    int unsigned bad   = 0;
    int unsigned exp_stalls = 0;
    int unsigned exp_grants = 0;
    logic [63:0] exp_q[$];
    logic [63:0] exp_v;
    logic [63:0] shadow [256];
    logic [63:0] mem    [256];
    logic        mem_ready = 1'b0;

    always #5 clk = ~clk;

    dmem_port_arbiter #(.MAX_WAIT(4)) dut (
        .clk              (clk),
        .reset            (reset),
        .cpu_rd_en        (cpu_rd_en),
        .cpu_wr_en        (cpu_wr_en),
        .cpu_addr         (cpu_addr),
        .cpu_wdata        (cpu_wdata),
        .cpu_rdata        (cpu_rdata),
        .cpu_stall        (cpu_stall),
        .aux_req          (aux_req),
        .aux_we           (aux_we),
        .aux_addr         (aux_addr),
        .aux_wdata        (aux_wdata),
        .aux_gnt          (aux_gnt),
        .aux_rdata        (aux_rdata),
        .aux_rvalid       (aux_rvalid),
        .mem_address      (mem_address),
        .mem_write_enable (mem_write_enable),
        .mem_read_enable  (mem_read_enable),
        .mem_write_data   (mem_write_data),
        .mem_xfer_size    (mem_xfer_size),
        .mem_read_data    (mem_read_data)
`ifdef DMEM_ARB_STATS_EN
        ,
        .stat_stall_cycles (stat_stall_cycles),
        .stat_aux_grants   (stat_aux_grants)
`endif
    );

    function automatic logic [63:0] pat(input int unsigned idx);
        return {32'hC0DE_F00D, idx};
    endfunction

    // Behavioural datamem: combinational read, write on the rising edge.
    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < 256; i++) mem[i] <= pat(i);
            mem_ready <= 1'b1;
        end else if (mem_write_enable) begin
            mem[mem_address[10:3]] <= mem_write_data;
        end
    end
    assign mem_read_data = mem[mem_address[10:3]];

    task automatic idle_inputs;
        cpu_rd_en = 1'b0; cpu_wr_en = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        aux_req = 1'b0; aux_we = 1'b0; aux_addr = '0; aux_wdata = '0;
    endtask

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        idle_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++; if (cpu_stall !== 1'b0) begin bad++; $display("FAIL rst_stall: got %b want 0", cpu_stall); end
        total++; if (aux_gnt !== 1'b0) begin bad++; $display("FAIL rst_gnt: got %b want 0", aux_gnt); end
        total++; if (aux_rvalid !== 1'b0) begin bad++; $display("FAIL rst_rvalid: got %b want 0", aux_rvalid); end
        total++; if ({mem_write_enable, mem_read_enable} !== 2'b00) begin bad++; $display("FAIL rst_en: got %b want 00", {mem_write_enable, mem_read_enable}); end
        total++; if (aux_rdata !== 64'h0) begin bad++; $display("FAIL rst_rdata: got %h want 0", aux_rdata); end
        total++; if (mem_xfer_size !== 4'd8) begin bad++; $display("FAIL xfer_size: got %0d want 8", mem_xfer_size); end
`ifdef DMEM_ARB_STATS_EN
        total++; if (stat_stall_cycles !== 32'd0 || stat_aux_grants !== 32'd0) begin bad++; $display("FAIL rst_stats: got %0d/%0d want 0/0", stat_stall_cycles, stat_aux_grants); end
`endif
        @(posedge clk); #1;
        reset = 1'b0;
        // Both requesters idle: data lines must read zero even with live address inputs.
        cpu_addr = 64'h123; cpu_wdata = 64'h55; aux_addr = 64'h99; aux_wdata = 64'h77;
        @(negedge clk);
        total++; if (mem_address !== 64'h0 || mem_write_data !== 64'h0) begin bad++; $display("FAIL idle_zero: got addr=%h wdata=%h want 0/0", mem_address, mem_write_data); end
        next_cycle();
        idle_inputs();
    endtask

    task automatic test_forced_grant;
        int unsigned k = 0;
        logic [63:0] a_addr;
        logic [63:0] c_addr;
        for (int r = 0; r < 3; r++) begin
            a_addr = 64'h200 + 64'(r * 8);
            for (int c = 1; c <= 5; c++) begin
                c_addr = 64'h100 + 64'(k * 8);
                aux_req = 1'b1; aux_we = 1'b0; aux_addr = a_addr;
                cpu_rd_en = 1'b1; cpu_addr = c_addr;
                @(negedge clk);
                total++; if (aux_gnt !== (c == 5)) begin bad++; $display("FAIL force_gnt r%0d c%0d: got %b want %b", r, c, aux_gnt, c == 5); end
                total++; if (cpu_stall !== (c == 5)) begin bad++; $display("FAIL force_stall r%0d c%0d: got %b want %b", r, c, cpu_stall, c == 5); end
                if (c == 5) begin
                    exp_q.push_back(shadow[a_addr[10:3]]);
                    exp_stalls++; exp_grants++;
                    total++; if (mem_address !== a_addr || mem_read_enable !== 1'b1) begin bad++; $display("FAIL force_addr r%0d: got %h/%b want %h/1", r, mem_address, mem_read_enable, a_addr); end
                end else begin
                    total++; if (mem_address !== c_addr || cpu_rdata !== shadow[c_addr[10:3]]) begin bad++; $display("FAIL cpu_load r%0d c%0d: got %h/%h want %h/%h", r, c, mem_address, cpu_rdata, c_addr, shadow[c_addr[10:3]]); end
                    k++;
                end
                if (c == 1 && r > 0) begin
                    exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hX;
                    total++; if (aux_rvalid !== 1'b1 || aux_rdata !== exp_v) begin bad++; $display("FAIL force_resp r%0d: got %b/%h want 1/%h", r, aux_rvalid, aux_rdata, exp_v); end
                end else begin
                    total++; if (aux_rvalid !== 1'b0) begin bad++; $display("FAIL force_norvalid r%0d c%0d: got %b want 0", r, c, aux_rvalid); end
                end
                next_cycle();
            end
        end
        // Replay of the last stalled CPU load with AUX released.
        c_addr = 64'h100 + 64'(k * 8);
        aux_req = 1'b0; cpu_addr = c_addr;
        @(negedge clk);
        total++; if (cpu_stall !== 1'b0 || aux_gnt !== 1'b0) begin bad++; $display("FAIL replay_ctl: got stall=%b gnt=%b want 0/0", cpu_stall, aux_gnt); end
        total++; if (mem_address !== c_addr || cpu_rdata !== shadow[c_addr[10:3]]) begin bad++; $display("FAIL replay_load: got %h/%h want %h/%h", mem_address, cpu_rdata, c_addr, shadow[c_addr[10:3]]); end
        exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hX;
        total++; if (aux_rvalid !== 1'b1 || aux_rdata !== exp_v) begin bad++; $display("FAIL replay_resp: got %b/%h want 1/%h", aux_rvalid, aux_rdata, exp_v); end
        next_cycle();
        idle_inputs();
    endtask

    task automatic test_idle_aux_read;
        aux_req = 1'b1; aux_we = 1'b0; aux_addr = 64'h40;
        @(negedge clk);
        total++; if (aux_gnt !== 1'b1 || cpu_stall !== 1'b0) begin bad++; $display("FAIL idle_gnt: got gnt=%b stall=%b want 1/0", aux_gnt, cpu_stall); end
        total++; if (mem_address !== 64'h40 || mem_read_enable !== 1'b1 || mem_write_enable !== 1'b0) begin bad++; $display("FAIL idle_mem: got %h rd=%b wr=%b want 40/1/0", mem_address, mem_read_enable, mem_write_enable); end
        exp_q.push_back(shadow[8]);
        exp_grants++;
        next_cycle();
        aux_req = 1'b0;
        @(negedge clk);
        exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hX;
        total++; if (aux_rvalid !== 1'b1 || aux_rdata !== exp_v) begin bad++; $display("FAIL idle_resp: got %b/%h want 1/%h", aux_rvalid, aux_rdata, exp_v); end
        next_cycle();
        @(negedge clk);
        total++; if (aux_rvalid !== 1'b0 || aux_rdata !== exp_v) begin bad++; $display("FAIL idle_hold: got %b/%h want 0/%h", aux_rvalid, aux_rdata, exp_v); end
        next_cycle();
    endtask

    task automatic test_aux_write;
        aux_req = 1'b1; aux_we = 1'b1; aux_addr = 64'h80; aux_wdata = 64'hDEAD_BEEF;
        @(negedge clk);
        total++; if (aux_gnt !== 1'b1 || mem_write_enable !== 1'b1 || mem_read_enable !== 1'b0) begin bad++; $display("FAIL wr_gnt: got gnt=%b wr=%b rd=%b want 1/1/0", aux_gnt, mem_write_enable, mem_read_enable); end
        total++; if (mem_address !== 64'h80 || mem_write_data !== 64'hDEAD_BEEF) begin bad++; $display("FAIL wr_mem: got %h/%h want 80/deadbeef", mem_address, mem_write_data); end
        shadow[16] = 64'hDEAD_BEEF;
        exp_grants++;
        next_cycle();
        idle_inputs();
        cpu_rd_en = 1'b1; cpu_addr = 64'h80;
        @(negedge clk);
        total++; if (cpu_rdata !== 64'hDEAD_BEEF) begin bad++; $display("FAIL wr_readback: got %h want deadbeef", cpu_rdata); end
        total++; if (aux_rvalid !== 1'b0) begin bad++; $display("FAIL wr_norvalid: got %b want 0", aux_rvalid); end
        next_cycle();
        idle_inputs();
    endtask

    task automatic test_stats;
`ifdef DMEM_ARB_STATS_EN
        @(negedge clk);
        total++; if (stat_stall_cycles !== 32'(exp_stalls)) begin bad++; $display("FAIL stat_stalls: got %0d want %0d", stat_stall_cycles, exp_stalls); end
        total++; if (stat_aux_grants !== 32'(exp_grants)) begin bad++; $display("FAIL stat_grants: got %0d want %0d", stat_aux_grants, exp_grants); end
        next_cycle();
`endif
    endtask

    task automatic test_back_to_back;
        aux_req = 1'b1; aux_we = 1'b0; aux_addr = 64'h40;
        @(negedge clk);
        total++; if (aux_gnt !== 1'b1) begin bad++; $display("FAIL b2b_gnt0: got %b want 1", aux_gnt); end
        exp_q.push_back(shadow[8]);
        next_cycle();
        aux_addr = 64'h80;
        @(negedge clk);
        total++; if (aux_gnt !== 1'b1 || mem_address !== 64'h80) begin bad++; $display("FAIL b2b_gnt1: got %b/%h want 1/80", aux_gnt, mem_address); end
        exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hX;
        total++; if (aux_rvalid !== 1'b1 || aux_rdata !== exp_v) begin bad++; $display("FAIL b2b_resp0: got %b/%h want 1/%h", aux_rvalid, aux_rdata, exp_v); end
        exp_q.push_back(shadow[16]);
        next_cycle();
        idle_inputs();
        @(negedge clk);
        exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hX;
        total++; if (aux_rvalid !== 1'b1 || aux_rdata !== exp_v) begin bad++; $display("FAIL b2b_resp1: got %b/%h want 1/%h", aux_rvalid, aux_rdata, exp_v); end
        next_cycle();
        @(negedge clk);
        total++; if (aux_rvalid !== 1'b0) begin bad++; $display("FAIL b2b_end: got %b want 0", aux_rvalid); end
        next_cycle();
    endtask

    task automatic test_reset_mid;
        aux_req = 1'b1; aux_we = 1'b0; aux_addr = 64'h208;
        @(negedge clk);
        total++; if (aux_gnt !== 1'b1) begin bad++; $display("FAIL rmid_gnt: got %b want 1", aux_gnt); end
        next_cycle();
        idle_inputs();
        reset = 1'b1;
        @(negedge clk);
        total++; if (aux_rvalid !== 1'b0 || aux_rdata !== 64'h0) begin bad++; $display("FAIL rmid_resp: got %b/%h want 0/0", aux_rvalid, aux_rdata); end
        total++; if ({cpu_stall, aux_gnt, mem_write_enable, mem_read_enable} !== 4'b0 || mem_address !== 64'h0) begin bad++; $display("FAIL rmid_outs: got %b/%h want 0000/0", {cpu_stall, aux_gnt, mem_write_enable, mem_read_enable}, mem_address); end
        exp_q.delete();
        next_cycle();
        reset = 1'b0;
        @(negedge clk);
        total++; if (aux_rvalid !== 1'b0) begin bad++; $display("FAIL rmid_after: got %b want 0", aux_rvalid); end
        next_cycle();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 256; i++) shadow[i] = pat(i);
        test_reset();
        test_forced_grant();
        test_idle_aux_read();
        test_aux_write();
        test_stats();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
